// File: rtl/csr_unit_ms.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit_ms
// Description : M+S-mode CSR file and trap/xret sequencer with delegation,
//               vectored tvec, free-running mcycle and a registered redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit_ms #(
    parameter int HARTID    = 0,
    parameter int DELEG_EN  = 1,
    parameter int VECTOR_EN = 1,
    parameter int PMP_N     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic [5:0]  trap_cause,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_tval,
    input  logic        xret_valid,
    input  logic        xret_is_s,
    input  logic [2:0]  irq_in,
    output logic        irq_take,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [1:0]  priv,
    output logic [63:0] satp_o,
    output logic [63:0] mstatus_o
);

    localparam logic [1:0]  c_priv_u = 2'b00;
    localparam logic [1:0]  c_priv_s = 2'b01;
    localparam logic [1:0]  c_priv_m = 2'b11;

    localparam logic [11:0] c_sstatus  = 12'h100;
    localparam logic [11:0] c_sie      = 12'h104;
    localparam logic [11:0] c_stvec    = 12'h105;
    localparam logic [11:0] c_sscratch = 12'h140;
    localparam logic [11:0] c_sepc     = 12'h141;
    localparam logic [11:0] c_scause   = 12'h142;
    localparam logic [11:0] c_stval    = 12'h143;
    localparam logic [11:0] c_sip      = 12'h144;
    localparam logic [11:0] c_satp     = 12'h180;
    localparam logic [11:0] c_mstatus  = 12'h300;
    localparam logic [11:0] c_misa     = 12'h301;
    localparam logic [11:0] c_medeleg  = 12'h302;
    localparam logic [11:0] c_mideleg  = 12'h303;
    localparam logic [11:0] c_mie      = 12'h304;
    localparam logic [11:0] c_mtvec    = 12'h305;
    localparam logic [11:0] c_mscratch = 12'h340;
    localparam logic [11:0] c_mepc     = 12'h341;
    localparam logic [11:0] c_mcause   = 12'h342;
    localparam logic [11:0] c_mtval    = 12'h343;
    localparam logic [11:0] c_mip      = 12'h344;
    localparam logic [11:0] c_mcycle   = 12'hB00;
    localparam logic [11:0] c_cycle    = 12'hC00;
    localparam logic [11:0] c_mvendor  = 12'hF11;
    localparam logic [11:0] c_marchid  = 12'hF12;
    localparam logic [11:0] c_mimpid   = 12'hF13;
    localparam logic [11:0] c_mhartid  = 12'hF14;

    localparam logic [63:0] c_mstatus_mask = 64'h0000_0000_007E_79BB;
    localparam logic [63:0] c_sstatus_mask = 64'h8000_0003_000D_E122;
    localparam logic [63:0] c_mip_wmask    = 64'h222;
    localparam logic [63:0] c_mie_mask     = 64'hAAA;
    localparam logic [63:0] c_medeleg_mask = (DELEG_EN != 0) ? 64'hB3FF : 64'h0;
    localparam logic [63:0] c_mideleg_mask = (DELEG_EN != 0) ? 64'h222 : 64'h0;
    localparam logic [63:0] c_tvec_mask    = (VECTOR_EN != 0) ? ~64'h2 : ~64'h3;
    localparam logic [63:0] c_epc_mask     = ~64'h1;
    localparam logic [63:0] c_pmp_mask     = 64'h003F_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_misa_val     = {2'b10, 36'b0, 26'h014_1100};
    localparam int          c_pmp_sz       = (PMP_N > 0) ? PMP_N : 1;

    logic [1:0]  r_priv;
    logic [63:0] r_mstatus, r_mtvec, r_stvec, r_mepc, r_sepc;
    logic [63:0] r_mcause, r_scause, r_mtval, r_stval;
    logic [63:0] r_mie, r_mip_soft, r_mscratch, r_sscratch, r_satp;
    logic [63:0] r_medeleg, r_mideleg, r_mcycle;
    logic [2:0]  r_irq;
    logic        r_redirect_valid;
    logic [63:0] r_redirect_pc;
    logic [63:0] r_pmpaddr [c_pmp_sz];

    logic [63:0] w_mip, w_rdata, w_new, w_ms_src, w_ms_wr;
    logic        w_known, w_writes, w_illegal, w_csr_we;
    logic [63:0] w_pend, w_irq_vec;
    logic        w_m_en, w_s_en;
    logic [5:0]  w_irq_cause;
    logic        w_xret, w_xret_bad, w_xret_ok, w_enter, w_ent_intr, w_to_s;
    logic [5:0]  w_ent_cause;
    logic [63:0] w_ent_tval, w_cause_full, w_deleg_bits, w_tvec, w_target;

    // Hardware interrupt lines live in mip[11/7/3] after one sampling stage.
    assign w_mip = r_mip_soft | {52'b0, r_irq[2], 3'b0, r_irq[1], 3'b0, r_irq[0], 3'b0};

    always_comb begin
        w_rdata = '0;
        w_known = 1'b1;
        case (csr_addr)
            c_sstatus:  w_rdata = r_mstatus & c_sstatus_mask;
            c_sie:      w_rdata = r_mie & r_mideleg;
            c_stvec:    w_rdata = r_stvec;
            c_sscratch: w_rdata = r_sscratch;
            c_sepc:     w_rdata = r_sepc;
            c_scause:   w_rdata = r_scause;
            c_stval:    w_rdata = r_stval;
            c_sip:      w_rdata = w_mip & r_mideleg;
            c_satp:     w_rdata = r_satp;
            c_mstatus:  w_rdata = r_mstatus;
            c_misa:     w_rdata = c_misa_val;
            c_medeleg:  w_rdata = r_medeleg;
            c_mideleg:  w_rdata = r_mideleg;
            c_mie:      w_rdata = r_mie;
            c_mtvec:    w_rdata = r_mtvec;
            c_mscratch: w_rdata = r_mscratch;
            c_mepc:     w_rdata = r_mepc;
            c_mcause:   w_rdata = r_mcause;
            c_mtval:    w_rdata = r_mtval;
            c_mip:      w_rdata = w_mip;
            c_mcycle:   w_rdata = r_mcycle;
            c_cycle:    w_rdata = r_mcycle;
            c_mvendor:  w_rdata = '0;
            c_marchid:  w_rdata = '0;
            c_mimpid:   w_rdata = '0;
            c_mhartid:  w_rdata = 64'(HARTID);
            default: begin
                w_known = 1'b0;
                for (int k = 0; k < PMP_N; k++) begin
                    if (csr_addr == 12'(32'h3B0 + k)) begin
                        w_rdata = r_pmpaddr[k];
                        w_known = 1'b1;
                    end
                end
            end
        endcase
    end

    assign csr_rdata = w_rdata;
    assign w_writes  = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != '0));
    assign w_illegal = !w_known || (csr_addr[9:8] > r_priv) ||
                       (w_writes && (csr_addr[11:10] == 2'b11));
    assign csr_illegal = csr_valid && w_illegal;

    always_comb begin
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_rdata | csr_wdata;
            2'b11:   w_new = w_rdata & ~csr_wdata;
            default: w_new = w_rdata;
        endcase
    end

    // sstatus merges into the mstatus backing store; MPP=10 is not a legal value.
    always_comb begin
        w_ms_src = (csr_addr == c_sstatus) ?
                   ((r_mstatus & ~c_sstatus_mask) | (w_new & c_sstatus_mask)) : w_new;
        w_ms_wr  = w_ms_src & c_mstatus_mask;
        if (w_ms_wr[12:11] == 2'b10) begin
            w_ms_wr[12:11] = r_mstatus[12:11];
        end
    end

    always_comb begin
        w_pend    = w_mip & r_mie;
        w_m_en    = (r_priv != c_priv_m) || r_mstatus[3];
        w_s_en    = (r_priv == c_priv_u) || ((r_priv == c_priv_s) && r_mstatus[1]);
        w_irq_vec = (w_pend & ~r_mideleg & {64{w_m_en}}) |
                    (w_pend & r_mideleg & {64{w_s_en}});
        if (w_irq_vec[11])      w_irq_cause = 6'd11;
        else if (w_irq_vec[3])  w_irq_cause = 6'd3;
        else if (w_irq_vec[7])  w_irq_cause = 6'd7;
        else if (w_irq_vec[9])  w_irq_cause = 6'd9;
        else if (w_irq_vec[1])  w_irq_cause = 6'd1;
        else                    w_irq_cause = 6'd5;
    end

    assign irq_take = |w_irq_vec;

    // Event arbitration: trap > interrupt > xret > CSR write.
    assign w_xret     = !trap_valid && !irq_take && xret_valid;
    assign w_xret_bad = w_xret && (xret_is_s ? (r_priv == c_priv_u) : (r_priv != c_priv_m));
    assign w_xret_ok  = w_xret && !w_xret_bad;
    assign w_enter    = trap_valid || irq_take || w_xret_bad;
    assign w_ent_intr = !trap_valid && irq_take;
    assign w_ent_cause = trap_valid ? trap_cause : (irq_take ? w_irq_cause : 6'd2);
    assign w_ent_tval  = trap_valid ? trap_tval : 64'd0;
    assign w_cause_full = {w_ent_intr, 57'b0, w_ent_cause};
    assign w_deleg_bits = w_ent_intr ? r_mideleg : r_medeleg;
    assign w_to_s = (DELEG_EN != 0) && (r_priv != c_priv_m) && w_deleg_bits[w_ent_cause];
    assign w_tvec = w_to_s ? r_stvec : r_mtvec;
    assign w_target = (w_tvec & ~64'h3) +
                      (((VECTOR_EN != 0) && w_tvec[0] && w_ent_intr) ?
                       {56'b0, w_ent_cause, 2'b00} : 64'd0);

    assign w_csr_we = csr_valid && !w_illegal && w_writes &&
                      !trap_valid && !irq_take && !xret_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_priv           <= c_priv_m;
            r_mstatus        <= '0;
            r_mtvec          <= '0;
            r_stvec          <= '0;
            r_mepc           <= '0;
            r_sepc           <= '0;
            r_mcause         <= '0;
            r_scause         <= '0;
            r_mtval          <= '0;
            r_stval          <= '0;
            r_mie            <= '0;
            r_mip_soft       <= '0;
            r_mscratch       <= '0;
            r_sscratch       <= '0;
            r_satp           <= '0;
            r_medeleg        <= '0;
            r_mideleg        <= '0;
            r_mcycle         <= '0;
            r_irq            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_irq            <= irq_in;
            r_mcycle         <= r_mcycle + 64'd1;
            r_redirect_valid <= 1'b0;
            if (w_enter) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= w_target;
                if (w_to_s) begin
                    r_sepc       <= trap_pc;
                    r_scause     <= w_cause_full;
                    r_stval      <= w_ent_tval;
                    r_mstatus[5] <= r_mstatus[1];
                    r_mstatus[1] <= 1'b0;
                    r_mstatus[8] <= r_priv[0];
                    r_priv       <= c_priv_s;
                end else begin
                    r_mepc           <= trap_pc;
                    r_mcause         <= w_cause_full;
                    r_mtval          <= w_ent_tval;
                    r_mstatus[7]     <= r_mstatus[3];
                    r_mstatus[3]     <= 1'b0;
                    r_mstatus[12:11] <= r_priv;
                    r_priv           <= c_priv_m;
                end
            end else if (w_xret_ok) begin
                r_redirect_valid <= 1'b1;
                if (xret_is_s) begin
                    r_redirect_pc <= r_sepc;
                    r_priv        <= {1'b0, r_mstatus[8]};
                    r_mstatus[1]  <= r_mstatus[5];
                    r_mstatus[5]  <= 1'b1;
                    r_mstatus[8]  <= 1'b0;
                end else begin
                    r_redirect_pc    <= r_mepc;
                    r_priv           <= r_mstatus[12:11];
                    r_mstatus[3]     <= r_mstatus[7];
                    r_mstatus[7]     <= 1'b1;
                    r_mstatus[12:11] <= c_priv_u;
                end
            end else if (w_csr_we) begin
                case (csr_addr)
                    c_sstatus,
                    c_mstatus:  r_mstatus  <= w_ms_wr;
                    c_sie:      r_mie      <= (r_mie & ~r_mideleg) | (w_new & r_mideleg & c_mie_mask);
                    c_stvec:    r_stvec    <= w_new & c_tvec_mask;
                    c_sscratch: r_sscratch <= w_new;
                    c_sepc:     r_sepc     <= w_new & c_epc_mask;
                    c_scause:   r_scause   <= w_new;
                    c_stval:    r_stval    <= w_new;
                    c_sip:      r_mip_soft <= (r_mip_soft & ~r_mideleg) |
                                              (w_new & r_mideleg & c_mip_wmask);
                    c_satp:     r_satp     <= w_new;
                    c_medeleg:  r_medeleg  <= w_new & c_medeleg_mask;
                    c_mideleg:  r_mideleg  <= w_new & c_mideleg_mask;
                    c_mie:      r_mie      <= w_new & c_mie_mask;
                    c_mtvec:    r_mtvec    <= w_new & c_tvec_mask;
                    c_mscratch: r_mscratch <= w_new;
                    c_mepc:     r_mepc     <= w_new & c_epc_mask;
                    c_mcause:   r_mcause   <= w_new;
                    c_mtval:    r_mtval    <= w_new;
                    c_mip:      r_mip_soft <= w_new & c_mip_wmask;
                    c_mcycle:   r_mcycle   <= w_new;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < c_pmp_sz; k++) begin
            if (reset) begin
                r_pmpaddr[k] <= '0;
            end else if ((k < PMP_N) && w_csr_we && (csr_addr == 12'(32'h3B0 + k))) begin
                r_pmpaddr[k] <= w_new & c_pmp_mask;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign priv           = r_priv;
    assign satp_o         = r_satp;
    assign mstatus_o      = r_mstatus;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit_ms.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit_ms
// Description : Directed self-checking bench for csr_unit_ms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit_ms;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_valid = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [63:0] csr_wdata = 64'h0;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [5:0]  trap_cause = 6'd0;
    logic [63:0] trap_pc = 64'h0;
    logic [63:0] trap_tval = 64'h0;
    logic        xret_valid = 1'b0;
    logic        xret_is_s = 1'b0;
    logic [2:0]  irq_in = 3'b000;
    logic        irq_take;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv;
    logic [63:0] satp_o;
    logic [63:0] mstatus_o;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    csr_unit_ms #(.HARTID(3), .DELEG_EN(1), .VECTOR_EN(1), .PMP_N(2)) dut (
        .clk(clk), .reset(reset),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .xret_valid(xret_valid), .xret_is_s(xret_is_s),
        .irq_in(irq_in), .irq_take(irq_take),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .priv(priv), .satp_o(satp_o), .mstatus_o(mstatus_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
        csr_valid = 1'b1; csr_op = 2'b00; csr_addr = a; csr_wdata = '0;
        #1;
        check(tag, csr_rdata, exp);
        csr_valid = 1'b0;
    endtask

    task automatic ill(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d,
                       input logic exp, input string tag);
        csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        #1;
        check(tag, 64'(csr_illegal), 64'(exp));
        csr_valid = 1'b0; csr_op = 2'b00;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
        csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        tick;
        csr_valid = 1'b0; csr_op = 2'b00;
    endtask

    task automatic trap(input logic [5:0] c, input logic [63:0] pc, input logic [63:0] tv);
        trap_valid = 1'b1; trap_cause = c; trap_pc = pc; trap_tval = tv;
        tick;
        trap_valid = 1'b0;
    endtask

    task automatic xret(input logic s);
        xret_valid = 1'b1; xret_is_s = s;
        tick;
        xret_valid = 1'b0;
    endtask

    task automatic redir(input logic [63:0] pc, input logic [1:0] p, input string tag);
        check({tag, "_valid"}, 64'(redirect_valid), 64'd1);
        check({tag, "_pc"}, redirect_pc, pc);
        check({tag, "_priv"}, 64'(priv), 64'(p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick;
        check("rst_rv", 64'(redirect_valid), 64'd0);
        check("rst_rpc", redirect_pc, 64'd0);
        check("rst_priv", 64'(priv), 64'd3);
        check("rst_mstatus", mstatus_o, 64'd0);
        check("rst_satp", satp_o, 64'd0);
        reset = 1'b0;
        tick; tick;
        rd(12'hF14, 64'd3, "mhartid");
        rd(12'h300, 64'd0, "mstatus_rst");
        rd(12'hB00, 64'd2, "mcycle_a");
        repeat (5) tick;
        rd(12'hB00, 64'd7, "mcycle_b");
        wr(2'b01, 12'hB00, 64'd100);
        rd(12'hB00, 64'd100, "mcycle_wr");
        tick;
        rd(12'hB00, 64'd101, "mcycle_inc");

        wr(2'b10, 12'h300, 64'h8);
        rd(12'h300, 64'h8, "csrrs_mstatus");
        wr(2'b11, 12'h300, 64'h8);
        rd(12'h300, 64'h0, "csrrc_mstatus");
        wr(2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h300, 64'h7E79BB, "mstatus_mask");
        rd(12'h100, 64'h0C6122, "sstatus_view");
        wr(2'b01, 12'h300, 64'h0);
        ill(2'b01, 12'hF14, 64'h1, 1'b1, "ill_ro_write");
        ill(2'b10, 12'hF14, 64'h0, 1'b0, "ill_ro_set0");
        ill(2'b00, 12'h7FF, 64'h0, 1'b1, "ill_unknown");
        wr(2'b01, 12'h180, 64'h8000_0000_0001_2345);
        check("satp_o", satp_o, 64'h8000_0000_0001_2345);
        wr(2'b01, 12'h3B1, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h3B1, 64'h003F_FFFF_FFFF_FFFF, "pmpaddr1");

        // Drop to U via MRET, then take a delegated ecall-from-U into S.
        wr(2'b01, 12'h302, 64'h100);
        wr(2'b01, 12'h105, 64'h8020_0000);
        wr(2'b01, 12'h305, 64'h8000_0001);
        wr(2'b01, 12'h341, 64'h2000);
        xret(1'b0);
        redir(64'h2000, 2'b00, "mret_to_u");
        check("mstatus_after_mret", mstatus_o, 64'h80);
        tick;
        check("pulse_one_cycle", 64'(redirect_valid), 64'd0);
        trap(6'd8, 64'h1000, 64'h0);
        redir(64'h8020_0000, 2'b01, "deleg_trap");
        rd(12'h141, 64'h1000, "sepc");
        rd(12'h142, 64'd8, "scause");
        ill(2'b00, 12'h300, 64'h0, 1'b1, "ill_mstatus_from_s");
        trap(6'd2, 64'h1004, 64'h55);
        redir(64'h8000_0000, 2'b11, "m_trap_vec_exc");
        rd(12'h341, 64'h1004, "mepc_exc");
        rd(12'h342, 64'd2, "mcause_exc");
        rd(12'h343, 64'h55, "mtval_exc");
        check("mstatus_m_entry", mstatus_o, 64'h800);

        // Machine timer interrupt through a vectored mtvec.
        wr(2'b10, 12'h300, 64'h8);
        wr(2'b01, 12'h304, 64'h80);
        irq_in = 3'b010;
        trap_pc = 64'h3000;
        #1;
        check("irq_take_presample", 64'(irq_take), 64'd0);
        tick;
        check("irq_take", 64'(irq_take), 64'd1);
        tick;
        irq_in = 3'b000;
        redir(64'h8000_001C, 2'b11, "irq_redirect");
        check("irq_take_after", 64'(irq_take), 64'd0);
        rd(12'h342, 64'h8000_0000_0000_0007, "mcause_irq");
        rd(12'h341, 64'h3000, "mepc_irq");
        rd(12'h343, 64'h0, "mtval_irq");
        check("mstatus_irq", mstatus_o, 64'h1880);

        // MRET to U, then an MRET from U must trap as illegal instruction.
        wr(2'b01, 12'h300, 64'h80);
        wr(2'b01, 12'h341, 64'h4000);
        tick;
        xret(1'b0);
        redir(64'h4000, 2'b00, "mret_u");
        check("mstatus_mret_u", mstatus_o, 64'h88);
        trap_pc = 64'h4000;
        xret(1'b0);
        redir(64'h8000_0000, 2'b11, "mret_from_u");
        rd(12'h342, 64'd2, "mcause_bad_mret");
        rd(12'h341, 64'h4000, "mepc_bad_mret");
        check("mstatus_bad_mret", mstatus_o, 64'h80);

        // A trap in the same cycle as a CSR write drops the write.
        wr(2'b01, 12'h340, 64'h1234);
        rd(12'h340, 64'h1234, "mscratch_wr");
        csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 64'hDEAD;
        trap(6'd3, 64'h5000, 64'h0);
        csr_valid = 1'b0; csr_op = 2'b00;
        redir(64'h8000_0000, 2'b11, "trap_vs_csr");
        rd(12'h340, 64'h1234, "mscratch_kept");

        // Back-to-back traps each pulse.
        trap_valid = 1'b1; trap_cause = 6'd3; trap_pc = 64'h6000; trap_tval = 64'h0;
        tick;
        check("b2b_first", 64'(redirect_valid), 64'd1);
        tick;
        trap_valid = 1'b0;
        check("b2b_second", 64'(redirect_valid), 64'd1);
        tick;
        check("b2b_idle", 64'(redirect_valid), 64'd0);

        // Reset during the redirect cycle, and reset together with a trap.
        trap(6'd3, 64'h7000, 64'h0);
        check("pre_reset_pulse", 64'(redirect_valid), 64'd1);
        reset = 1'b1;
        tick;
        check("reset_kills_pulse", 64'(redirect_valid), 64'd0);
        check("reset_rpc", redirect_pc, 64'd0);
        trap(6'd3, 64'h7004, 64'h0);
        check("reset_vs_trap", 64'(redirect_valid), 64'd0);
        rd(12'h341, 64'h0, "mepc_under_reset");
        reset = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
